// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO path: default depth,
// pointer-width helper and the packed status word.
package fifo_pkg;

  localparam int FIFO_DEPTH_DEFAULT = 4;

  // Pointer width: index bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer: low bits index the storage array, the MSB flips on
// every pass so equal indices can be told apart as full or empty.
module fifo_ptr #(
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  // Advance by one on each enabled cycle; natural roll-over handles wrap.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/sync_fifo_reader.sv
// Circular-buffer FIFO with a registered read port. Occupancy and
// full/empty are derived from the two wrap-bit pointers only, so every
// data value (including zero) is ordinary payload.
//
// Handshake: wr and rd are single-cycle requests sampled at each rising
// edge. A push is accepted when wr && !full, a pop when rd && !empty,
// both judged on the state before the edge. Rejected requests are dropped
// and reported by a one-cycle overflow/underflow strobe. An accepted pop
// presents its word on dout one cycle later, qualified by dout_valid.
module sync_fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = FIFO_DEPTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    wr,
  input  logic                    rd,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_valid,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_idx;
  logic [AW-1:0]         rd_idx;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  ovf_q;
  logic                  unf_q;
  fifo_status_t          status;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  // Pointers are flops, so these flags already reflect the previous edge.
  assign status.empty     = (wr_ptr == rd_ptr);
  assign status.full      = (wr_idx == rd_idx) && (wr_ptr[PW-1] != rd_ptr[PW-1]);
  assign status.overflow  = ovf_q;
  assign status.underflow = unf_q;

  assign push_ok = wr && !status.full;
  assign pop_ok  = rd && !status.empty;

  fifo_ptr #(.PTR_W(PW)) u_wr_ptr (
    .clk    (clk),
    .resetn (resetn),
    .inc    (push_ok),
    .ptr    (wr_ptr)
  );

  fifo_ptr #(.PTR_W(PW)) u_rd_ptr (
    .clk    (clk),
    .resetn (resetn),
    .inc    (pop_ok),
    .ptr    (rd_ptr)
  );

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (resetn && push_ok) begin
      mem[wr_idx] <= din;
    end
  end

  // Read register and one-cycle strobes; dout holds unless a pop is taken.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      dout_valid <= pop_ok;
      ovf_q      <= wr && status.full;
      unf_q      <= rd && status.empty;
      if (pop_ok) begin
        dout <= mem[rd_idx];
      end
    end
  end

  assign count     = wr_ptr - rd_ptr;
  assign full      = status.full;
  assign empty     = status.empty;
  assign overflow  = status.overflow;
  assign underflow = status.underflow;

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Bench for sync_fifo_reader: a queue-based model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_sync_fifo_reader;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] din;
  logic          wr;
  logic          rd;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  always #5 clk = ~clk;

  sync_fifo_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .wr         (wr),
    .rd         (rd),
    .dout       (dout),
    .dout_valid (dout_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic check_en = 1'b0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_dout;
  logic          m_valid;
  logic          m_ovf;
  logic          m_unf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words, updated from the requests
  // seen at each edge using the occupancy before that edge.
  always @(posedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      check_en = 1'b1;
    end else begin
      bit do_pop;
      bit do_push;
      do_pop  = rd && (exp_q.size() > 0);
      do_push = wr && (exp_q.size() < DEPTH);
      if (do_pop) m_dout = exp_q.pop_front();
      if (do_push) exp_q.push_back(din);
      m_valid = do_pop;
      m_ovf   = wr && !do_push;
      m_unf   = rd && !do_pop;
    end
  end

  // Every-cycle comparison, sampled mid-period.
  always @(negedge clk) begin
    if (check_en) begin
      check("dout",       32'(dout),       32'(m_dout));
      check("dout_valid", 32'(dout_valid), 32'(m_valid));
      check("full",       32'(full),       32'(exp_q.size() == DEPTH));
      check("empty",      32'(empty),      32'(exp_q.size() == 0));
      check("count",      32'(count),      32'(exp_q.size()));
      check("overflow",   32'(overflow),   32'(m_ovf));
      check("underflow",  32'(underflow),  32'(m_unf));
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    wr  = w;
    rd  = r;
    din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] seq [4];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;

    resetn = 1'b0;
    wr = 1'b0; rd = 1'b0; din = '0;
    repeat (3) step(1'b0, 1'b0, '0);
    resetn = 1'b1;

    // 1. idle after reset
    repeat (10) step(1'b0, 1'b0, '0);
    check("idle_empty", 32'(empty), 32'd1);
    check("idle_count", 32'(count), 32'd0);
    check("idle_dout",  32'(dout),  32'd0);

    // 2. fill, then one push too many
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, seq[i]);
    check("fill_full",  32'(full),  32'd1);
    check("fill_count", 32'(count), 32'd4);
    step(1'b1, 1'b0, 8'h55);
    check("ovf_strobe", 32'(overflow), 32'd1);
    check("ovf_count",  32'(count),    32'd4);
    step(1'b0, 1'b0, '0);
    check("ovf_clear",  32'(overflow), 32'd0);

    // 3. drain in order, then one pop too many
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, '0);
      check("drain_dout",  32'(dout),       32'(seq[i]));
      check("drain_valid", 32'(dout_valid), 32'd1);
    end
    step(1'b0, 1'b1, '0);
    check("unf_strobe", 32'(underflow),  32'd1);
    check("unf_hold",   32'(dout),       32'h44);
    check("unf_valid",  32'(dout_valid), 32'd0);

    // 4. zero is payload
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, '0);
    check("zero_dout",  32'(dout),       32'h00);
    check("zero_valid", 32'(dout_valid), 32'd1);
    check("zero_empty", 32'(empty),      32'd1);

    // 5. steady simultaneous traffic at count 2
    step(1'b1, 1'b0, 8'd1);
    step(1'b1, 1'b0, 8'd2);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b1, DW'(i + 2));
      check("steady_dout",  32'(dout),  32'(i));
      check("steady_count", 32'(count), 32'd2);
    end
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);

    // 6. simultaneous requests at the empty and full boundaries, then reset
    step(1'b1, 1'b1, 8'hAA);
    check("emp_unf",   32'(underflow),  32'd1);
    check("emp_count", 32'(count),      32'd1);
    check("emp_valid", 32'(dout_valid), 32'd0);
    step(1'b1, 1'b0, 8'hB1);
    step(1'b1, 1'b0, 8'hB2);
    step(1'b1, 1'b0, 8'hB3);
    step(1'b1, 1'b1, 8'hCC);
    check("full_ovf",   32'(overflow),   32'd1);
    check("full_dout",  32'(dout),       32'hAA);
    check("full_valid", 32'(dout_valid), 32'd1);
    check("full_count", 32'(count),      32'd3);
    resetn = 1'b0;
    step(1'b0, 1'b0, '0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_dout",  32'(dout),  32'd0);
    resetn = 1'b1;
    step(1'b0, 1'b0, '0);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      resetn = ($urandom_range(0, 59) != 0);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)));
    end
    resetn = 1'b1;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
